cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction controller in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against the stored flags.
- Gates the controller's PCSrc, we (data-memory write) and we3 (register-file write) so that an instruction whose condition fails has no side effects.
- Keeps saturating counters of executed and squashed instructions for debug and performance.

Parameters:
- CNT_W, 16, width of the exec_cnt and squash_cnt counters.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- instr_valid, input, 1: current instruction is valid; when low, no flag update, no counting, all gated enables 0.
- Cond, input, 4: instruction condition field, bits [31:28].
- Op, input, 2: instruction op field; 00 = data processing.
- S, input, 1: Funct[0], set-flags bit.
- ALUControl, input, 3: from the controller; 000 add, 001 sub, 010 and, 011 orr, 101 eor, 110 mvn.
- ALUFlagOut, input, 4: {N,Z,C,V} from the ALU for the current instruction.
- PCSrc, input, 1: ungated controller output.
- we, input, 1: ungated controller output.
- we3, input, 1: ungated controller output.
- clr_cnt, input, 1: synchronous clear of both counters.
- PCSrc_g, output, 1: PCSrc & CondEx & instr_valid & reset.
- we_g, output, 1: we & CondEx & instr_valid & reset.
- we3_g, output, 1: we3 & CondEx & instr_valid & reset.
- CondEx, output, 1: combinational condition result against the registered flags.
- Flags, output, 4: registered {N,Z,C,V}.
- exec_cnt, output, CNT_W: saturating count of valid instructions with CondEx = 1.
- squash_cnt, output, CNT_W: saturating count of valid instructions with CondEx = 0.

Behaviour:
- Reset (reset == 0 at the clock edge): Flags <= 4'b0000; exec_cnt <= 0; squash_cnt <= 0.
  - While reset is low, PCSrc_g, we_g and we3_g are forced to 0 combinationally.
  - CondEx still reflects the stored Flags.
- CondEx is combinational, zero latency, computed from the registered Flags (never from ALUFlagOut):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1 (unconditional)
- Flag write enables: FlagW[1] = (Op == 00) & S. FlagW[0] = FlagW[1] & (ALUControl == 000 or ALUControl == 001).
- Flag update, at the rising edge when reset == 1, instr_valid == 1 and CondEx == 1:
  - If FlagW[1], {N,Z} <= ALUFlagOut[3:2].
  - If FlagW[0], {C,V} <= ALUFlagOut[1:0].
  - Otherwise the flags hold.
  - Logic ops with S set update N and Z only; C and V are preserved.
- The new flags are visible to the next instruction's CondEx one cycle later. The current instruction never sees its own flags.
- Counters, at the rising edge when reset == 1:
  - If clr_cnt == 1, both counters <= 0. Clear has priority over increment in the same cycle.
  - Else, if instr_valid == 1: increment exec_cnt when CondEx == 1, otherwise increment squash_cnt.
  - Each counter saturates at 2^CNT_W − 1 and never wraps.
- Priority: reset > clr_cnt > increment. Reset mid-stream discards any flag update from that cycle.
- Op == 11 or any X on the control inputs: gated enables follow the equations above. No extra protection.

Decomposition:
- Shared package cond_pkg:
  - Condition-code localparams COND_EQ through COND_AL.
  - ALUControl encodings ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MVN, shared with the controller.
  - OP_DP, OP_MEM, OP_BR.
  - typedef flags_t as a packed struct {n, z, c, v}.
- Sub-module cond_check: purely combinational (Cond, flags_t) -> CondEx, instantiated once. Flag register, gating and counters stay in the top.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with we3 = 1 and Cond = 1110 -> Flags = 0000, we3_g = 0, both counters 0. Release -> we3_g = 1.
- SUBS sets flags: Op = 00, S = 1, ALUControl = 001, ALUFlagOut = 0110, Cond = 1110. Next cycle Flags = 0110. A following Cond = 0000 (EQ) with we3 = 1 -> we3_g = 1, CondEx = 1.
- Squash: Flags = 0100 (Z = 1), Cond = 0001 (NE), PCSrc = 1, we = 1, Op = 00, S = 1 -> PCSrc_g = 0, we_g = 0, Flags unchanged, squash_cnt increments by 1.
- Logic op partial update: Flags = 0011, ANDS (ALUControl = 010, S = 1), ALUFlagOut = 1000, Cond = 1110 -> Flags = 1011 (C and V preserved).
- Signed conditions: Flags = 1000 (N = 1, V = 0) -> GE CondEx = 0, LT = 1, GT = 0, LE = 1. Flags = 1001 -> GE = 1, GT = 1.
- Counters: CNT_W = 4, 20 valid AL instructions -> exec_cnt = 15 (saturated). clr_cnt asserted together with a valid instruction -> exec_cnt = 0 next cycle.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution stage and the instruction controller.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b101;
  localparam logic [2:0] ALU_MVN = 3'b110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against a flag set.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     flags,
  output logic       CondEx
);

  logic ge;

  assign ge = (flags.n == flags.v);

  always_comb begin
    CondEx = 1'b1;
    unique case (Cond)
      COND_EQ: CondEx = flags.z;
      COND_NE: CondEx = ~flags.z;
      COND_CS: CondEx = flags.c;
      COND_CC: CondEx = ~flags.c;
      COND_MI: CondEx = flags.n;
      COND_PL: CondEx = ~flags.n;
      COND_VS: CondEx = flags.v;
      COND_VC: CondEx = ~flags.v;
      COND_HI: CondEx = flags.c & ~flags.z;
      COND_LS: CondEx = ~flags.c | flags.z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~flags.z & ge;
      COND_LE: CondEx = flags.z | ~ge;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, enable gating and exec/squash counters.
module cond_logic
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [3:0]       Cond,
  input  logic [1:0]       Op,
  input  logic             S,
  input  logic [2:0]       ALUControl,
  input  logic [3:0]       ALUFlagOut,
  input  logic             PCSrc,
  input  logic             we,
  input  logic             we3,
  input  logic             clr_cnt,
  output logic             PCSrc_g,
  output logic             we_g,
  output logic             we3_g,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  flags_t             flags_q, flags_d;
  flags_t             alu_flags;
  logic [1:0]         flag_w;
  logic               fire;
  logic [CNT_W-1:0]   exec_q, exec_d;
  logic [CNT_W-1:0]   squash_q, squash_d;

  cond_check u_cond_check (
    .Cond   (Cond),
    .flags  (flags_q),
    .CondEx (CondEx)
  );

  assign alu_flags = flags_t'(ALUFlagOut);
  assign flag_w[1] = (Op == OP_DP) & S;
  assign flag_w[0] = flag_w[1] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));

  // reset is folded in so enables drop immediately while reset is held low
  assign fire    = CondEx & instr_valid & reset;
  assign PCSrc_g = PCSrc & fire;
  assign we_g    = we & fire;
  assign we3_g   = we3 & fire;

  always_comb begin
    flags_d = flags_q;
    if (instr_valid && CondEx) begin
      if (flag_w[1]) begin
        flags_d.n = alu_flags.n;
        flags_d.z = alu_flags.z;
      end
      if (flag_w[0]) begin
        flags_d.c = alu_flags.c;
        flags_d.v = alu_flags.v;
      end
    end
  end

  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (clr_cnt) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (instr_valid) begin
      if (CondEx) begin
        if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
      end else begin
        if (squash_q != '1) squash_d = squash_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q  <= '0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign Flags      = flags_q;
  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: reference model plus directed literal checks.
module tb_cond_logic;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic [3:0]       Cond;
  logic [1:0]       Op;
  logic             S;
  logic [2:0]       ALUControl;
  logic [3:0]       ALUFlagOut;
  logic             PCSrc, we, we3, clr_cnt;
  logic             PCSrc_g, we_g, we3_g, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt, squash_cnt;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .Cond(Cond), .Op(Op), .S(S),
    .ALUControl(ALUControl), .ALUFlagOut(ALUFlagOut), .PCSrc(PCSrc), .we(we), .we3(we3),
    .clr_cnt(clr_cnt), .PCSrc_g(PCSrc_g), .we_g(we_g), .we3_g(we3_g), .CondEx(CondEx),
    .Flags(Flags), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [3:0] m_flags = 4'b0000;
  int         m_exec = 0;
  int         m_squash = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Odd conditions are the inverse of the even one below them; 111x is always true.
  function automatic bit mcond(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_flags = 4'b0000; m_exec = 0; m_squash = 0;
    end else begin
      bit ce;
      ce = mcond(m_flags, Cond);
      if (instr_valid && ce && Op == 2'b00 && S) begin
        m_flags[3:2] = ALUFlagOut[3:2];
        if (ALUControl == 3'b000 || ALUControl == 3'b001) m_flags[1:0] = ALUFlagOut[1:0];
      end
      if (clr_cnt) begin
        m_exec = 0; m_squash = 0;
      end else if (instr_valid) begin
        if (ce) m_exec = (m_exec < MAXC) ? m_exec + 1 : MAXC;
        else    m_squash = (m_squash < MAXC) ? m_squash + 1 : MAXC;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ce, en;
      ce = mcond(m_flags, Cond);
      en = ce && instr_valid && reset;
      check("CondEx", 32'(CondEx), 32'(ce));
      check("PCSrc_g", 32'(PCSrc_g), 32'(en && PCSrc));
      check("we_g", 32'(we_g), 32'(en && we));
      check("we3_g", 32'(we3_g), 32'(en && we3));
      check("Flags", 32'(Flags), 32'(m_flags));
      check("exec_cnt", 32'(exec_cnt), 32'(m_exec));
      check("squash_cnt", 32'(squash_cnt), 32'(m_squash));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] c, input logic s, input logic [2:0] alu, input logic [3:0] afo);
    instr_valid = 1'b1; Cond = c; Op = 2'b00; S = s; ALUControl = alu; ALUFlagOut = afo;
  endtask

  initial begin
    reset = 1'b0; clr_cnt = 1'b0; PCSrc = 1'b0; we = 1'b0; we3 = 1'b1;
    instr(4'b1110, 1'b0, 3'b000, 4'b0000);
    step(); chk_en = 1;
    step(); #1;
    check("rst_flags", 32'(Flags), 32'h0);
    check("rst_we3_g", 32'(we3_g), 32'h0);
    check("rst_exec", 32'(exec_cnt), 32'h0);
    check("rst_squash", 32'(squash_cnt), 32'h0);
    reset = 1'b1; #1;
    check("rel_we3_g", 32'(we3_g), 32'h1);

    instr(4'b1110, 1'b1, 3'b001, 4'b0110); step(); #1;
    check("subs_flags", 32'(Flags), 32'h6);
    instr(4'b0000, 1'b0, 3'b000, 4'b0000); #1;
    check("eq_condex", 32'(CondEx), 32'h1);
    check("eq_we3_g", 32'(we3_g), 32'h1);
    step();

    instr(4'b1110, 1'b1, 3'b001, 4'b0100); step();
    instr(4'b0001, 1'b1, 3'b001, 4'b1111); PCSrc = 1'b1; we = 1'b1; #1;
    check("ne_pcsrc_g", 32'(PCSrc_g), 32'h0);
    check("ne_we_g", 32'(we_g), 32'h0);
    step(); #1;
    check("ne_flags", 32'(Flags), 32'h4);
    check("ne_squash", 32'(squash_cnt), 32'h1);
    PCSrc = 1'b0; we = 1'b0;

    instr(4'b1110, 1'b1, 3'b001, 4'b0011); step();
    instr(4'b1110, 1'b1, 3'b010, 4'b1000); step(); #1;
    check("ands_flags", 32'(Flags), 32'hB);

    instr(4'b1110, 1'b1, 3'b001, 4'b1000); step();
    S = 1'b0;
    Cond = 4'b1010; #1 check("ge_n1v0", 32'(CondEx), 32'h0);
    Cond = 4'b1011; #1 check("lt_n1v0", 32'(CondEx), 32'h1);
    Cond = 4'b1100; #1 check("gt_n1v0", 32'(CondEx), 32'h0);
    Cond = 4'b1101; #1 check("le_n1v0", 32'(CondEx), 32'h1);
    step();
    instr(4'b1110, 1'b1, 3'b001, 4'b1001); step();
    S = 1'b0;
    Cond = 4'b1010; #1 check("ge_n1v1", 32'(CondEx), 32'h1);
    Cond = 4'b1100; #1 check("gt_n1v1", 32'(CondEx), 32'h1);
    step();

    // sweep every condition over several flag states with mixed controls
    for (int f = 0; f < 16; f += 5) begin
      instr(4'b1111, 1'b1, 3'b000, 4'(f)); step();
      for (int c = 0; c < 16; c++) begin
        instr(4'(c), c[1], 3'(c % 7), 4'(15 - c));
        instr_valid = (c % 5) != 3;
        Op = (c % 4 == 2) ? 2'b11 : 2'b00;
        PCSrc = c[0]; we = c[2]; we3 = c[3];
        step();
      end
    end
    PCSrc = 1'b0; we = 1'b0; we3 = 1'b1;

    instr(4'b1110, 1'b0, 3'b000, 4'b0000); clr_cnt = 1'b1; step(); clr_cnt = 1'b0; #1;
    check("clr_exec", 32'(exec_cnt), 32'h0);
    check("clr_squash", 32'(squash_cnt), 32'h0);
    for (int i = 0; i < 20; i++) step();
    #1 check("sat_exec", 32'(exec_cnt), 32'hF);
    Cond = 4'b0000;
    for (int i = 0; i < 18; i++) step();
    #1 check("sat_squash", 32'(squash_cnt), 32'hF);
    Cond = 4'b1110; clr_cnt = 1'b1; step(); clr_cnt = 1'b0; #1;
    check("clr_pri_exec", 32'(exec_cnt), 32'h0);

    instr(4'b1110, 1'b1, 3'b000, 4'b1111); step();
    instr(4'b1110, 1'b1, 3'b011, 4'b0000); reset = 1'b0; step(); #1;
    check("midrst_flags", 32'(Flags), 32'h0);
    reset = 1'b1;
    instr_valid = 1'b0; S = 1'b1; ALUFlagOut = 4'b1111; step(); #1;
    check("invalid_flags", 32'(Flags), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
